// File: rtl/data_select_pkg.sv
// Shared opcode definitions for data_select_pipe and its stage-2 ALU.
package data_select_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    OP_PASS_A = 3'b000,
    OP_PASS_B = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_ACC    = 3'b100,
    OP_LOAD   = 3'b101,
    OP_MAX    = 3'b110,
    OP_MIN    = 3'b111
  } opcode_e;

  // Opcodes whose result becomes the new accumulator value.
  function automatic logic op_writes_acc(input opcode_e op);
    return (op == OP_ACC) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/data_select_alu.sv
// Stage-2 combinational arithmetic for data_select_pipe.
// Optional build macro DATA_SELECT_SAT_EN: an overflowing ACC clamps to the
// signed ACC_W range instead of wrapping. ovf is raised in both builds.
module data_select_alu
  import data_select_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  opcode_e                 op_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] result_o,
  output logic                    ovf_o
);

`ifdef DATA_SELECT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp a one-bit-wider sum to the signed ACC_W range.
  function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction
`else
  // Keep the low ACC_W bits: wrap modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [ACC_W:0] s);
    return s[ACC_W-1:0];
  endfunction
`endif

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W:0]   acc_sum;

  // Operands are sign-extended first; ACC_W >= WIDTH+1 makes ADD/SUB exact.
  assign a_ext   = ACC_W'(a_i);
  assign b_ext   = ACC_W'(b_i);
  assign acc_sum = (ACC_W+1)'(acc_i) + (ACC_W+1)'(a_ext);

  // Opcode decode; only ACC can overflow.
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      OP_PASS_A: result_o = a_ext;
      OP_PASS_B: result_o = b_ext;
      OP_ADD:    result_o = a_ext + b_ext;
      OP_SUB:    result_o = a_ext - b_ext;
      OP_ACC: begin
        result_o = fit_acc(acc_sum);
        ovf_o    = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
      end
      OP_LOAD:   result_o = a_ext;
      OP_MAX:    result_o = (a_ext > b_ext) ? a_ext : b_ext;
      OP_MIN:    result_o = (a_ext < b_ext) ? a_ext : b_ext;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_select_pipe.sv
// Two-stage operand-select / arithmetic pipeline with an internal accumulator.
// Stage 1 registers the operands and opcode, stage 2 registers the ALU result.
// One advance enable (en) moves both stages; in_ready mirrors it.
// Optional build macro DATA_SELECT_SAT_EN: saturating ACC (see data_select_alu).
module data_select_pipe
  import data_select_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [SEL_W-1:0]        select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] c,
  output logic                    ovf
);

  if (WIDTH < 2) begin : g_chk_width
    $error("data_select_pipe: WIDTH must be at least 2");
  end
  if (ACC_W < WIDTH + 1) begin : g_chk_acc_w
    $error("data_select_pipe: ACC_W must be at least WIDTH+1");
  end

  logic                    en;

  logic                    vld_p1_q;
  logic signed [WIDTH-1:0] a_p1_q;
  logic signed [WIDTH-1:0] b_p1_q;
  opcode_e                 sel_p1_q;

  logic                    vld_p2_q, vld_p2_d;
  logic signed [ACC_W-1:0] c_p2_q, c_p2_d;
  logic                    ovf_p2_q, ovf_p2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [ACC_W-1:0] alu_res;
  logic                    alu_ovf;

  assign en        = out_ready || !vld_p2_q;
  assign in_ready  = en;
  assign out_valid = vld_p2_q;
  assign c         = c_p2_q;
  assign ovf       = ovf_p2_q;

  // ---- stage 1: operand capture ----
  // Stage-1 valid bit; a rejected or absent beat enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
    end
  end

  // Stage-1 operands/opcode; qualified by vld_p1_q so left without reset.
  always_ff @(posedge clk) begin
    if (en) begin
      a_p1_q   <= a;
      b_p1_q   <= b;
      sel_p1_q <= opcode_e'(select);
    end
  end

  // ---- stage 2: arithmetic and result register ----
  data_select_alu #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_alu (
    .a_i     (a_p1_q),
    .b_i     (b_p1_q),
    .op_i    (sel_p1_q),
    .acc_i   (acc_q),
    .result_o(alu_res),
    .ovf_o   (alu_ovf)
  );

  // Next-state for stage 2; bubbles leave c, ovf and the accumulator untouched.
  always_comb begin
    vld_p2_d = vld_p2_q;
    c_p2_d   = c_p2_q;
    ovf_p2_d = ovf_p2_q;
    acc_d    = acc_q;
    if (en) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        c_p2_d   = alu_res;
        ovf_p2_d = alu_ovf;
        if (op_writes_acc(sel_p1_q)) acc_d = alu_res;
      end
    end
  end

  // Stage-2 registers; the accumulator is written in the same cycle as its
  // result so back-to-back ACC beats see each other's updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      c_p2_q   <= '0;
      ovf_p2_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      c_p2_q   <= c_p2_d;
      ovf_p2_q <= ovf_p2_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_data_select_pipe.sv
// Self-checking bench for data_select_pipe (WIDTH=8, ACC_W=9): directed cases
// plus randomized traffic scored against a queue-based reference model.
module tb_data_select_pipe;
  import data_select_pkg::*;

  localparam int WIDTH   = 8;
  localparam int ACC_W   = 9;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));
  localparam int SPAN    = 1 << ACC_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic [2:0]              select;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] c;
  logic                    ovf;

  data_select_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .select   (select),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int c; bit ovf;} exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   got_c[$];
  bit   got_ovf[$];
  int   m_acc = 0;
  bit   chk_en = 0;
  bit   post_rst = 0;
  bit   hold_v = 0;
  int   hold_c = 0;
  bit   hold_ovf = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted beat, in acceptance order.
  function automatic void model_op(input logic [2:0] sel, input int av, input int bv,
                                   input int acc_in, output int r, output bit ov,
                                   output int acc_out);
    int s;
    r = 0; ov = 0; acc_out = acc_in;
    case (sel)
      OP_PASS_A: r = av;
      OP_PASS_B: r = bv;
      OP_ADD:    r = av + bv;
      OP_SUB:    r = av - bv;
      OP_ACC: begin
        s = acc_in + av;
        if (s > ACC_MAX || s < ACC_MIN) begin
          ov = 1;
`ifdef DATA_SELECT_SAT_EN
          r = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
          r = (s > ACC_MAX) ? s - SPAN : s + SPAN;
`endif
        end else begin
          r = s;
        end
        acc_out = r;
      end
      OP_LOAD: begin r = av; acc_out = av; end
      OP_MAX:  r = (av > bv) ? av : bv;
      default: r = (av < bv) ? av : bv;
    endcase
  endfunction

  // Single compare process: outputs vs model on every cycle.
  always @(negedge clk) begin
    int r, na;
    bit ov;
    exp_t e;
    if (chk_en) begin
      if (post_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_ovf", ovf, 0);
      end
      post_rst = 0;
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_c", c, hold_c);
        chk("hold_ovf", ovf, hold_ovf);
      end
      chk("in_ready", in_ready, (out_ready || !out_valid) ? 1 : 0);
      if (out_valid) begin
        chk("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          chk("c", c, exp_q[0].c);
          chk("ovf", ovf, exp_q[0].ovf);
        end
      end
      if (rst) begin
        exp_q.delete();
        m_acc = 0;
        hold_v = 0;
        post_rst = 1;
      end else begin
        hold_v   = out_valid && !out_ready;
        hold_c   = c;
        hold_ovf = ovf;
        if (out_valid && out_ready && exp_q.size() > 0) begin
          got_c.push_back(c);
          got_ovf.push_back(ovf);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          model_op(select, a, b, m_acc, r, ov, na);
          m_acc = na;
          e.c = r;
          e.ovf = ov;
          exp_q.push_back(e);
        end
        chk("in_flight_le2", (exp_q.size() <= 2) ? 1 : 0, 1);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] s, input int av, input int bv,
                       input logic ordy);
    @(posedge clk); #1;
    in_valid  = v;
    select    = s;
    a         = WIDTH'(av);
    b         = WIDTH'(bv);
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, OP_PASS_A, 0, 0, 1);
  endtask

  task automatic chk_got(input string nm, input int idx, input int ec, input bit eo);
    if (idx < got_c.size()) begin
      chk({nm, "_c"}, got_c[idx], ec);
      chk({nm, "_ovf"}, got_ovf[idx], eo);
    end else begin
      chk({nm, "_present"}, 0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, na;
    bit ov;
    rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; select = 0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_c", c, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);

    // pin the model with hand-computed values
    model_op(OP_ADD, 127, 127, 0, r, ov, na);   chk("pin_add", r, 254);
    model_op(OP_SUB, -128, 127, 0, r, ov, na);  chk("pin_sub", r, -255);
    model_op(OP_MIN, -3, 5, 0, r, ov, na);      chk("pin_min", r, -3);
    model_op(OP_ACC, 100, 0, 200, r, ov, na);   chk("pin_acc_ovf", ov, 1);
`ifdef DATA_SELECT_SAT_EN
    chk("pin_acc_sat", r, 255);
`else
    chk("pin_acc_wrap", r, -212);
`endif

    // ADD latency: result visible exactly two cycles after acceptance
    drive(1, OP_ADD, 127, 127, 1);
    drive(0, OP_PASS_A, 0, 0, 1);
    @(negedge clk);
    chk("add_lat1_valid", out_valid, 0);
    @(negedge clk);
    chk("add_lat2_valid", out_valid, 1);
    chk("add_c", c, 254);
    chk("add_ovf", ovf, 0);
    idle(3);

    // SUB and MIN back-to-back
    got_c.delete(); got_ovf.delete();
    drive(1, OP_SUB, -128, 127, 1);
    drive(1, OP_MIN, -3, 5, 1);
    idle(4);
    chk("sub_min_count", got_c.size(), 2);
    chk_got("sub", 0, -255, 0);
    chk_got("min", 1, -3, 0);

    // LOAD then three ACC back-to-back
    got_c.delete(); got_ovf.delete();
    drive(1, OP_LOAD, 100, 0, 1);
    drive(1, OP_ACC, 100, 0, 1);
    drive(1, OP_ACC, 100, 0, 1);
    drive(1, OP_ACC, 100, 0, 1);
    idle(4);
    chk("acc_count", got_c.size(), 4);
    chk_got("load", 0, 100, 0);
    chk_got("acc1", 1, 200, 0);
`ifdef DATA_SELECT_SAT_EN
    chk_got("acc2", 2, 255, 1);
    chk_got("acc3", 3, 255, 1);
`else
    chk_got("acc2", 2, -212, 1);
    chk_got("acc3", 3, -112, 0);
`endif

    // back-pressure: out_ready low for 3 cycles with two beats in flight
    got_c.delete(); got_ovf.delete();
    drive(1, OP_PASS_A, 11, 0, 1);
    drive(1, OP_PASS_B, 0, 22, 1);
    drive(0, OP_PASS_A, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_c", c, 11);
      if (i < 2) @(posedge clk);
    end
    drive(0, OP_PASS_A, 0, 0, 1);
    idle(4);
    chk("stall_count", got_c.size(), 2);
    chk_got("stall0", 0, 11, 0);
    chk_got("stall1", 1, 22, 0);

    // reset with two ACC beats in flight
    drive(1, OP_ACC, 7, 0, 1);
    drive(1, OP_ACC, 9, 0, 1);
    @(posedge clk); #1;
    rst = 1; in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    got_c.delete(); got_ovf.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    drive(1, OP_ACC, 5, 0, 1);
    idle(4);
    chk("flush_count", got_c.size(), 1);
    chk_got("acc_after_rst", 0, 5, 0);

    // randomized traffic with stalls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      select    = 3'($urandom);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    rst = 0;
    idle(5);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
